viterbi_frame_ctrl: RTL and testbench

//   Frame sequencer for the K=3, rate-1/2 Viterbi datapath (BMU -> ACS -> TBU).
//   - Accepts soft/hard symbol pairs from the channel side.
//   - Per frame: clears path metrics, feeds FRAME_LEN data symbols, inserts tail symbols,

---
 rtl/viterbi_frame_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_viterbi_frame_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_frame_ctrl.sv
// -----------------------------------------------------------------------------
// viterbi_frame_ctrl
//   Frame sequencer for a K=3, rate-1/2 Viterbi datapath (BMU -> ACS -> TBU).
//   One frame:
//     IDLE -> INIT  : one-cycle path-metric clear pulse to the datapath
//          -> DATA  : FRAME_LEN channel symbols forwarded, one per accept
//          -> TAIL  : TAIL_LEN zero symbols (encoder termination)
//          -> FLUSH : TBL+1 zero symbols so the traceback, which only moves
//                     on dp_valid_o, pushes out the last decoded bits
//          -> DRAIN : wait for the remaining decoded bits
//          -> DONE  : one-cycle done pulse, counters cleared -> IDLE
//   Exactly FRAME_LEN decoded bits are forwarded per frame; extra TBU outputs
//   (tail/flush decisions) are dropped.
//
//   Optional feature macro: VITERBI_CTRL_ABORT_EN
//     Adds abort_i. abort_i in any non-IDLE state returns to IDLE on the next
//     cycle with all outputs low and no done pulse.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   start_i          frame start request, only looked at in IDLE
//   sym_i[1:0]       received symbol pair {g1,g0}
//   sym_valid_i      sym_i valid
//   sym_ready_o      controller takes sym_i this cycle
//   dp_pm_init_o     one-cycle path-metric clear pulse
//   dp_sym_o[1:0]    symbol to the BMU
//   dp_valid_o       datapath advance strobe
//   dp_bit_i         decoded bit from the TBU
//   dp_bit_valid_i   dp_bit_i valid
//   bit_o            decoded output bit
//   bit_valid_o      bit_o valid
//   busy_o           high in every state except IDLE
//   done_o           one-cycle pulse at frame completion
//   abort_i          (VITERBI_CTRL_ABORT_EN only) frame abort
//
// Handshake: a symbol is transferred on a rising edge where both sym_valid_i
// and sym_ready_o are high. sym_ready_o is registered and does not depend on
// sym_valid_i; the source must hold sym_i stable while sym_valid_i is high and
// sym_ready_o is low.
// -----------------------------------------------------------------------------
module viterbi_frame_ctrl #(
   parameter int FRAME_LEN = 64,
   parameter int TAIL_LEN  = 2,
   parameter int TBL       = 15,
   parameter int CNT_W     = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_i,
`ifdef VITERBI_CTRL_ABORT_EN
   input  logic       abort_i,
`endif
   input  logic [1:0] sym_i,
   input  logic       sym_valid_i,
   output logic       sym_ready_o,
   output logic       dp_pm_init_o,
   output logic [1:0] dp_sym_o,
   output logic       dp_valid_o,
   input  logic       dp_bit_i,
   input  logic       dp_bit_valid_i,
   output logic       bit_o,
   output logic       bit_valid_o,
   output logic       busy_o,
   output logic       done_o
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      INIT  = 3'd1,
      DATA  = 3'd2,
      TAIL  = 3'd3,
      FLUSH = 3'd4,
      DRAIN = 3'd5,
      DONE  = 3'd6
   } state_t;

   localparam logic [CNT_W-1:0] FRAME_LEN_C  = CNT_W'(FRAME_LEN);
   localparam logic [CNT_W-1:0] TAIL_LAST_C  = CNT_W'(TAIL_LEN - 1);
   localparam logic [CNT_W-1:0] FLUSH_LAST_C = CNT_W'(TBL);
   localparam logic [CNT_W-1:0] ONE_C        = CNT_W'(1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] in_cnt_q, in_cnt_d;     // symbols accepted this frame
   logic [CNT_W-1:0] ph_cnt_q, ph_cnt_d;     // cycles spent in TAIL / FLUSH
   logic [CNT_W-1:0] out_cnt_q, out_cnt_d;   // decoded bits forwarded

   logic       sym_ready_q, sym_ready_d;
   logic       pm_init_q, pm_init_d;
   logic [1:0] dp_sym_q, dp_sym_d;
   logic       dp_valid_q, dp_valid_d;
   logic       bit_q, bit_d;
   logic       bit_valid_q, bit_valid_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;

   logic accept;
   logic in_frame;
   logic fwd;
   logic abort_w;

`ifdef VITERBI_CTRL_ABORT_EN
   assign abort_w = abort_i & (state_q != IDLE);
`else
   assign abort_w = 1'b0;
`endif

   // sym_ready_q is only ever high in DATA, so it also qualifies the state.
   assign accept   = sym_valid_i & sym_ready_q;
   assign in_frame = (state_q == DATA) || (state_q == TAIL) ||
                     (state_q == FLUSH) || (state_q == DRAIN);
   assign fwd      = dp_bit_valid_i & in_frame & (out_cnt_q < FRAME_LEN_C);

   always_comb begin
      state_d     = state_q;
      in_cnt_d    = in_cnt_q;
      ph_cnt_d    = ph_cnt_q;
      out_cnt_d   = out_cnt_q;
      sym_ready_d = 1'b0;
      pm_init_d   = 1'b0;
      dp_sym_d    = 2'b00;
      dp_valid_d  = 1'b0;
      bit_d       = 1'b0;
      bit_valid_d = 1'b0;
      done_d      = 1'b0;

      // Output path runs alongside the sequencer; bits beyond FRAME_LEN are
      // tail/flush decisions and are dropped.
      if (fwd) begin
         out_cnt_d   = out_cnt_q + ONE_C;
         bit_valid_d = 1'b1;
         bit_d       = dp_bit_i;
      end

      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d   = INIT;
               pm_init_d = 1'b1;
            end
         end
         INIT: begin
            state_d     = DATA;
            sym_ready_d = 1'b1;
         end
         DATA: begin
            sym_ready_d = 1'b1;
            if (accept) begin
               dp_sym_d   = sym_i;
               dp_valid_d = 1'b1;
               in_cnt_d   = in_cnt_q + ONE_C;
               // Ready drops together with the last accept so the cycle in
               // which the count reaches FRAME_LEN already shows ready low.
               if (in_cnt_q + ONE_C == FRAME_LEN_C) begin
                  sym_ready_d = 1'b0;
                  state_d     = TAIL;
                  ph_cnt_d    = '0;
               end
            end
         end
         TAIL: begin
            dp_valid_d = 1'b1;
            if (ph_cnt_q == TAIL_LAST_C) begin
               state_d  = FLUSH;
               ph_cnt_d = '0;
            end else begin
               ph_cnt_d = ph_cnt_q + ONE_C;
            end
         end
         FLUSH: begin
            dp_valid_d = 1'b1;
            if (ph_cnt_q == FLUSH_LAST_C) begin
               ph_cnt_d = '0;
               if (out_cnt_q == FRAME_LEN_C) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = DRAIN;
               end
            end else begin
               ph_cnt_d = ph_cnt_q + ONE_C;
            end
         end
         DRAIN: begin
            if (out_cnt_q == FRAME_LEN_C) begin
               state_d = DONE;
               done_d  = 1'b1;
            end
         end
         DONE: begin
            state_d   = IDLE;
            in_cnt_d  = '0;
            ph_cnt_d  = '0;
            out_cnt_d = '0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (abort_w) begin
         state_d     = IDLE;
         in_cnt_d    = '0;
         ph_cnt_d    = '0;
         out_cnt_d   = '0;
         sym_ready_d = 1'b0;
         pm_init_d   = 1'b0;
         dp_sym_d    = 2'b00;
         dp_valid_d  = 1'b0;
         bit_d       = 1'b0;
         bit_valid_d = 1'b0;
         done_d      = 1'b0;
      end

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         in_cnt_q    <= '0;
         ph_cnt_q    <= '0;
         out_cnt_q   <= '0;
         sym_ready_q <= 1'b0;
         pm_init_q   <= 1'b0;
         dp_sym_q    <= 2'b00;
         dp_valid_q  <= 1'b0;
         bit_q       <= 1'b0;
         bit_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_cnt_q    <= in_cnt_d;
         ph_cnt_q    <= ph_cnt_d;
         out_cnt_q   <= out_cnt_d;
         sym_ready_q <= sym_ready_d;
         pm_init_q   <= pm_init_d;
         dp_sym_q    <= dp_sym_d;
         dp_valid_q  <= dp_valid_d;
         bit_q       <= bit_d;
         bit_valid_q <= bit_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign sym_ready_o  = sym_ready_q;
   assign dp_pm_init_o = pm_init_q;
   assign dp_sym_o     = dp_sym_q;
   assign dp_valid_o   = dp_valid_q;
   assign bit_o        = bit_q;
   assign bit_valid_o  = bit_valid_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_viterbi_frame_ctrl
//   Bench for viterbi_frame_ctrl with FRAME_LEN=8, TAIL_LEN=2, TBL=15.
//   The channel source encodes random info bits with the K=3 (7,5) code.
//   The TBU stand-in counts datapath advances since the frame start and, once
//   LAT advances have gone by, returns info bit (advance - LAT), optionally
//   after a fixed extra delay. The decoded stream must therefore equal the
//   info bits, and the symbol stream must be the encoded bits followed by
//   TAIL_LEN+TBL+1 zero symbols.
// -----------------------------------------------------------------------------
module tb_viterbi_frame_ctrl;

   localparam int FRAME_LEN = 8;
   localparam int TAIL_LEN  = 2;
   localparam int TBL       = 15;
   localparam int CNT_W     = 8;
   localparam int N_VALID   = FRAME_LEN + TAIL_LEN + TBL + 1;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       start_i = 1'b0;
`ifdef VITERBI_CTRL_ABORT_EN
   logic       abort_i = 1'b0;
`endif
   logic [1:0] sym_i = 2'b00;
   logic       sym_valid_i = 1'b0;
   logic       sym_ready_o;
   logic       dp_pm_init_o;
   logic [1:0] dp_sym_o;
   logic       dp_valid_o;
   logic       dp_bit_i = 1'b0;
   logic       dp_bit_valid_i = 1'b0;
   logic       bit_o;
   logic       bit_valid_o;
   logic       busy_o;
   logic       done_o;

   viterbi_frame_ctrl #(
      .FRAME_LEN (FRAME_LEN),
      .TAIL_LEN  (TAIL_LEN),
      .TBL       (TBL),
      .CNT_W     (CNT_W)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start_i        (start_i),
`ifdef VITERBI_CTRL_ABORT_EN
      .abort_i        (abort_i),
`endif
      .sym_i          (sym_i),
      .sym_valid_i    (sym_valid_i),
      .sym_ready_o    (sym_ready_o),
      .dp_pm_init_o   (dp_pm_init_o),
      .dp_sym_o       (dp_sym_o),
      .dp_valid_o     (dp_valid_o),
      .dp_bit_i       (dp_bit_i),
      .dp_bit_valid_i (dp_bit_valid_i),
      .bit_o          (bit_o),
      .bit_valid_o    (bit_valid_o),
      .busy_o         (busy_o),
      .done_o         (done_o)
   );

   // scoreboard
   int n_vec = 0;
   int n_err = 0;
   logic [1:0] exp_sym_q[$];
   logic       exp_bit_q[$];
   int         tbu_due_q[$];
   logic       tbu_bit_q[$];

   // frame / model state
   logic       info[FRAME_LEN];
   logic [1:0] enc[FRAME_LEN];
   int  cyc = 0;
   int  src_mode = 0;
   int  lat = TBL + 1;
   int  dly = 0;
   int  src_idx = 0;
   int  nvalid = 0;
   bit  frame_active = 1'b0;
   bit  prev_accept = 1'b0;
   int  run_len = 0;
   int  max_run = 0;
   int  bits_seen = 0;
   int  done_seen = 0;
   int  init_seen = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // One clock: observe outputs on the falling edge, run the models, then
   // drive the inputs for the next rising edge.
   task cycle();
      int idx;
      logic b;
      bit hold;
      bit v;
      @(negedge clk);
      cyc++;
      if (dp_pm_init_o === 1'b1) init_seen++;
      if (done_o === 1'b1) done_seen++;
      if (bit_valid_o === 1'b1) begin
         bits_seen++;
         if (exp_bit_q.size() == 0) check("bit_extra", 1, 0);
         else check("bit_val", bit_o, exp_bit_q.pop_front());
      end
      // During the data phase a datapath advance must follow an accept, and
      // only an accept.
      if (frame_active && nvalid < FRAME_LEN && (dp_valid_o === 1'b1 || prev_accept))
         check("dp_after_accept", dp_valid_o, prev_accept);
      if (dp_valid_o === 1'b1) begin
         run_len++;
         if (run_len > max_run) max_run = run_len;
         if (exp_sym_q.size() == 0) check("sym_extra", 1, 0);
         else check("dp_sym", dp_sym_o, exp_sym_q.pop_front());
         if (nvalid >= lat) begin
            idx = nvalid - lat;
            b = (idx < FRAME_LEN) ? info[idx] : 1'($urandom);
            tbu_due_q.push_back(cyc + dly);
            tbu_bit_q.push_back(b);
         end
         nvalid++;
      end else begin
         run_len = 0;
      end
      // TBU stand-in
      if (tbu_due_q.size() != 0 && tbu_due_q[0] <= cyc) begin
         void'(tbu_due_q.pop_front());
         dp_bit_i = tbu_bit_q.pop_front();
         dp_bit_valid_i = 1'b1;
      end else begin
         dp_bit_i = 1'($urandom);
         dp_bit_valid_i = 1'b0;
      end
      // Channel source: valid is held until it is taken.
      if (!frame_active || rst) begin
         sym_valid_i = 1'b0;
         prev_accept = 1'b0;
      end else begin
         hold = sym_valid_i && !prev_accept;
         if (!hold) begin
            case (src_mode)
               0: v = 1'b1;
               1: v = (cyc % 3 == 0);
               default: v = 1'($urandom_range(0, 1));
            endcase
            sym_valid_i = v && (src_idx < FRAME_LEN);
         end
         sym_i = sym_valid_i ? enc[src_idx] : 2'($urandom);
         prev_accept = sym_valid_i && (sym_ready_o === 1'b1);
         if (prev_accept) src_idx++;
      end
   endtask

   task setup_frame(input int mode, input int latency, input int extra_dly);
      logic s1, s2;
      s1 = 1'b0;
      s2 = 1'b0;
      exp_sym_q.delete();
      exp_bit_q.delete();
      tbu_due_q.delete();
      tbu_bit_q.delete();
      for (int i = 0; i < FRAME_LEN; i++) begin
         info[i] = 1'($urandom);
         enc[i]  = {info[i] ^ s2, info[i] ^ s1 ^ s2};
         s2 = s1;
         s1 = info[i];
         exp_sym_q.push_back(enc[i]);
         exp_bit_q.push_back(info[i]);
      end
      for (int i = 0; i < TAIL_LEN + TBL + 1; i++) exp_sym_q.push_back(2'b00);
      src_mode = mode;
      lat = latency;
      dly = extra_dly;
      src_idx = 0;
      nvalid = 0;
      run_len = 0;
      max_run = 0;
      bits_seen = 0;
      done_seen = 0;
      init_seen = 0;
      prev_accept = 1'b0;
      frame_active = 1'b1;
   endtask

   task run_frame(input int mode, input int latency, input int extra_dly,
                  input bit poke_start, input bit hold_start);
      bit poked;
      int budget;
      poked = 1'b0;
      setup_frame(mode, latency, extra_dly);
      start_i = 1'b1;
      cycle();
      start_i = hold_start;
      budget = 0;
      while (done_seen == 0 && budget < 400) begin
         cycle();
         budget++;
         if (poke_start && !poked && nvalid == 3) begin
            start_i = 1'b1;
            poked = 1'b1;
         end else begin
            start_i = hold_start;
         end
      end
      if (done_seen == 0) check("done_timeout", 0, 1);
      for (int i = 0; i < 4; i++) cycle();
      start_i = 1'b0;
      check("done_cnt", done_seen, 1);
      check("init_cnt", init_seen, hold_start ? 2 : 1);
      check("bit_cnt", bits_seen, FRAME_LEN);
      check("sym_left", exp_sym_q.size(), 0);
      check("bits_left", exp_bit_q.size(), 0);
      if (mode == 0) check("valid_run", max_run, N_VALID);
      check("busy_after", busy_o, hold_start ? 1 : 0);
      frame_active = 1'b0;
   endtask

   task check_quiet(input string tag);
      check({tag, "_busy"}, busy_o, 0);
      check({tag, "_ready"}, sym_ready_o, 0);
      check({tag, "_pm_init"}, dp_pm_init_o, 0);
      check({tag, "_dp_valid"}, dp_valid_o, 0);
      check({tag, "_dp_sym"}, dp_sym_o, 0);
      check({tag, "_bit"}, bit_o, 0);
      check({tag, "_bit_valid"}, bit_valid_o, 0);
      check({tag, "_done"}, done_o, 0);
   endtask

   task do_reset();
      frame_active = 1'b0;
      start_i = 1'b0;
      rst = 1'b1;
      cycle();
      cycle();
      check_quiet("reset");
      exp_sym_q.delete();
      exp_bit_q.delete();
      tbu_due_q.delete();
      tbu_bit_q.delete();
      rst = 1'b0;
   endtask

   // Kill a frame in FLUSH with rst (use_abort=0) or abort_i (use_abort=1).
   task kill_in_flush(input bit use_abort);
      int budget;
      setup_frame(0, TBL + 1, 0);
      start_i = 1'b1;
      cycle();
      start_i = 1'b0;
      budget = 0;
      while (nvalid < FRAME_LEN + TAIL_LEN + 4 && budget < 200) begin
         cycle();
         budget++;
      end
      if (nvalid < FRAME_LEN + TAIL_LEN + 4) check("flush_timeout", 0, 1);
      frame_active = 1'b0;
      exp_sym_q.delete();
      exp_bit_q.delete();
      tbu_due_q.delete();
      tbu_bit_q.delete();
      done_seen = 0;
      bits_seen = 0;
`ifdef VITERBI_CTRL_ABORT_EN
      if (use_abort) abort_i = 1'b1;
      else rst = 1'b1;
`else
      if (!use_abort) rst = 1'b1;
`endif
      cycle();
      rst = 1'b0;
`ifdef VITERBI_CTRL_ABORT_EN
      abort_i = 1'b0;
`endif
      check_quiet(use_abort ? "abort" : "kill");
      for (int i = 0; i < 30; i++) cycle();
      check("kill_no_done", done_seen, 0);
      check("kill_no_bits", bits_seen, 0);
   endtask

   initial begin
      do_reset();
      run_frame(0, TBL + 1, 0, 1'b0, 1'b0);   // back-to-back source, direct FLUSH->DONE
      run_frame(1, TBL + 1, 0, 1'b1, 1'b0);   // every 3rd cycle, start poked in DATA
      run_frame(0, 6, 0, 1'b0, 1'b0);         // TBU returns 20 bits
      run_frame(2, TBL + 1, 0, 1'b0, 1'b0);   // random source
      run_frame(2, TBL + 1, 10, 1'b0, 1'b1);  // late bits (DRAIN), start held high
      do_reset();
      kill_in_flush(1'b0);
      run_frame(1, TBL + 1, 3, 1'b0, 1'b0);
`ifdef VITERBI_CTRL_ABORT_EN
      kill_in_flush(1'b1);
      run_frame(0, TBL + 1, 0, 1'b0, 1'b0);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
